// File: rtl/cnn_pkg.sv
// Shared CNN accelerator definitions: default array geometry and skew feeder state encodings.
package cnn_pkg;

    localparam int unsigned ARRAY_SIZE_DEF = 9;
    localparam int unsigned DATA_SIZE_DEF  = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2
    } feed_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Parameterised synchronous FIFO with registered full/empty flags; head entry readable combinationally.
module sync_fifo #(
    parameter int unsigned width = 8,
    parameter int unsigned depth = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [width-1:0] wr_data,
    input  logic             rd_en,
    output logic [width-1:0] rd_data_c,
    output logic             full,
    output logic             empty
);

    localparam int unsigned aw = $clog2(depth);
    localparam int unsigned cw = aw + 1;

    logic [width-1:0] mem [depth];
    logic [aw-1:0]    wr_ptr;
    logic [aw-1:0]    rd_ptr;
    logic [cw-1:0]    count;
    logic [cw-1:0]    count_nxt;
    logic             push;
    logic             pop;

    assign push      = wr_en && !full;
    assign pop       = rd_en && !empty;
    assign rd_data_c = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + cw'(1);
            2'b01:   count_nxt = count - cw'(1);
            default: count_nxt = count;
        endcase
    end

    // Storage carries no reset; validity is tracked entirely by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + aw'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + aw'(1);
            end
            count <= count_nxt;
            full  <= (count_nxt == cw'(depth));
            empty <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Buffers activation vectors and drives the systolic array with a per-lane diagonal skew.
// Define SKEW_FEEDER_RELU_EN to clamp negative lanes to zero at FIFO write.
module systolic_skew_feeder
    import cnn_pkg::*;
#(
    parameter int unsigned array_size = ARRAY_SIZE_DEF,
    parameter int unsigned data_size  = DATA_SIZE_DEF,
    parameter int unsigned fifo_depth = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [data_size*array_size-1:0] in_vec,
    input  logic                            in_last,
    output logic [data_size*array_size-1:0] dataout,
    output logic [array_size-1:0]           lane_valid,
    output logic                            frame_done,
    output logic                            busy
);

    localparam int unsigned vec_w = data_size * array_size;
    localparam int unsigned ent_w = vec_w + 1;
    localparam int unsigned cnt_w = $clog2(array_size);

    feed_state_e      state;
    logic [cnt_w-1:0] flush_cnt;

    logic [vec_w-1:0] wr_vec_c;
    logic [ent_w-1:0] rd_data_c;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop_c;
    logic             pop_last_c;

    logic [vec_w-1:0] issue_data;
    logic             issue_valid;
    logic             issue_last;

`ifdef SKEW_FEEDER_RELU_EN
    for (genvar g = 0; g < int'(array_size); g++) begin : g_clamp
        assign wr_vec_c[g*data_size +: data_size] =
            in_vec[(g+1)*data_size-1] ? '0 : in_vec[g*data_size +: data_size];
    end
`else
    assign wr_vec_c = in_vec;
`endif

    assign in_ready   = reset && !fifo_full;
    assign pop_c      = (state != ST_FLUSH) && !fifo_empty;
    assign pop_last_c = rd_data_c[vec_w];
    assign busy       = (state != ST_IDLE) || !fifo_empty;

    sync_fifo #(
        .width (ent_w),
        .depth (fifo_depth)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (in_valid && in_ready),
        .wr_data   ({in_last, wr_vec_c}),
        .rd_en     (pop_c),
        .rd_data_c (rd_data_c),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Frame sequencer: a popped last vector forces array_size-1 bubble slots.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            flush_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_STREAM: begin
                    if (pop_c) begin
                        if (pop_last_c) begin
                            state     <= ST_FLUSH;
                            flush_cnt <= cnt_w'(array_size - 1);
                        end else begin
                            state <= ST_STREAM;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt <= cnt_w'(1)) begin
                        state     <= ST_IDLE;
                        flush_cnt <= '0;
                    end else begin
                        flush_cnt <= flush_cnt - cnt_w'(1);
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    flush_cnt <= '0;
                end
            endcase
        end
    end

    // Issue slot: popped vector or a zero bubble, every cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            issue_data  <= '0;
            issue_valid <= 1'b0;
            issue_last  <= 1'b0;
        end else begin
            issue_data  <= pop_c ? rd_data_c[vec_w-1:0] : '0;
            issue_valid <= pop_c;
            issue_last  <= pop_c && pop_last_c;
        end
    end

    for (genvar g = 0; g < int'(array_size); g++) begin : g_lane
        if (g == 0) begin : g_direct
            assign dataout[data_size-1:0] = issue_data[data_size-1:0];
            assign lane_valid[0]          = issue_valid;
        end else begin : g_skew
            logic [data_size-1:0] dly_d [g];
            logic [g-1:0]         dly_v;

            always_ff @(posedge clk) begin
                if (!reset) begin
                    for (int k = 0; k < g; k++) begin
                        dly_d[k] <= '0;
                    end
                    dly_v <= '0;
                end else begin
                    dly_d[0] <= issue_data[g*data_size +: data_size];
                    dly_v[0] <= issue_valid;
                    for (int k = 1; k < g; k++) begin
                        dly_d[k] <= dly_d[k-1];
                        dly_v[k] <= dly_v[k-1];
                    end
                end
            end

            assign dataout[g*data_size +: data_size] = dly_d[g-1];
            assign lane_valid[g]                     = dly_v[g-1];

            // The last flag rides alongside the final lane so frame_done lines up with it.
            if (g == int'(array_size) - 1) begin : g_last
                logic [g-1:0] dly_l;

                always_ff @(posedge clk) begin
                    if (!reset) begin
                        dly_l <= '0;
                    end else begin
                        dly_l[0] <= issue_last;
                        for (int k = 1; k < g; k++) begin
                            dly_l[k] <= dly_l[k-1];
                        end
                    end
                end

                assign frame_done = dly_l[g-1];
            end
        end
    end

endmodule
